// File: rtl/dec32_rr_arbiter_if.sv
// Request/grant bundle between the requester logic and the 32-way round-robin arbiter.
interface dec32_rr_arbiter_if;
  logic        en;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/dec32_rr_arbiter.sv
// Round-robin arbiter for one 32-way one-hot decoded resource (IDLE -> BUSY -> GAP).
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module dec32_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               rst_n,
  dec32_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  last;
  logic [4:0]  idx_q;
  logic        valid_q;

  logic [4:0]  start;
  logic [31:0] req_rot;
  logic [4:0]  offset;
  logic [4:0]  winner;
  logic        any_req;
  logic        release_req;
  logic [31:0] gnt_dec;

  // Lowest set bit of the rotated vector, i.e. the first requester at or after start.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int j = 31; j >= 0; j--) begin
      if (v[j]) r = 5'(j);
    end
    return r;
  endfunction

  assign start   = last + 5'd1;
  assign any_req = |bus.req;

  always_comb begin
    req_rot = '0;
    for (int j = 0; j < 32; j++) begin
      req_rot[j] = bus.req[start + 5'(j)];
    end
  end

  assign offset      = lowest_set(req_rot);
  assign winner      = start + offset;
  assign release_req = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 5'd31;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.en && any_req) begin
            idx_q   <= winner;
            last    <= winner;
            valid_q <= 1'b1;
            state   <= BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        BUSY: begin
          // A normal release outranks a forced one landing on the same edge.
          if (release_req) begin
            valid_q <= 1'b0;
            state   <= GAP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            state     <= GAP;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant decode: idx[4:3] picks one of four 8-line banks, idx[2:0] the line within it.
  always_comb begin
    gnt_dec = '0;
    for (int b = 0; b < 4; b++) begin
      if (valid_q && (idx_q[4:3] == 2'(b))) begin
        gnt_dec[b*8 +: 8] = 8'b1 << idx_q[2:0];
      end
    end
  end

  assign bus.gnt       = gnt_dec;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_dec32_rr_arbiter.sv
// Self-checking bench for dec32_rr_arbiter: cycle model feeding a scoreboard plus directed checks.
module tb_dec32_rr_arbiter;

  localparam int MAX_HOLD_TB = 4;

  logic clk;
  logic rst_n;

  dec32_rr_arbiter_if bus ();

  dec32_rr_arbiter #(.MAX_HOLD(MAX_HOLD_TB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] gnt;
    logic [4:0]  idx;
    logic        vld;
    logic        to;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state;
  int m_last;
  int m_idx;
  int m_vld;
  int m_to;
  int m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0;
    m_last  = 31;
    m_idx   = 0;
    m_vld   = 0;
    m_to    = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(input logic e, input logic [31:0] r, input logic d);
    int  c;
    int  w;
    bit  found;
    m_to = 0;
    case (m_state)
      0: begin
        if (e && r != 32'd0) begin
          found = 0;
          w = 0;
          for (int k = 1; k <= 32; k++) begin
            c = (m_last + k) % 32;
            if (!found && r[c]) begin
              found = 1;
              w = c;
            end
          end
          m_idx   = w;
          m_last  = w;
          m_vld   = 1;
          m_cnt   = 0;
          m_state = 1;
        end
      end
      1: begin
        if (d || !r[m_idx]) begin
          m_vld   = 0;
          m_state = 2;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_cnt == MAX_HOLD_TB - 1) begin
          m_vld   = 0;
          m_to    = 1;
          m_state = 2;
        end else begin
          m_cnt++;
        end
`endif
      end
      default: m_state = 0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.gnt = m_vld ? (32'd1 << m_idx) : 32'd0;
    x.idx = 5'(m_idx);
    x.vld = m_vld[0];
    x.to  = m_to[0];
    return x;
  endfunction

  task automatic tick(input logic e, input logic [31:0] r, input logic d);
    exp_t x;
    @(negedge clk);
    bus.en   = e;
    bus.req  = r;
    bus.done = d;
    model_step(e, r, d);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("sb_gnt",       64'(bus.gnt),       64'(x.gnt));
    check("sb_gnt_idx",   64'(bus.gnt_idx),   64'(x.idx));
    check("sb_gnt_valid", 64'(bus.gnt_valid), 64'(x.vld));
    check("sb_timeout",   64'(bus.timeout),   64'(x.to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.req  = 32'hFFFF_FFFF;
    bus.done = 1'b0;
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    check("rst_gnt",       64'(bus.gnt),       64'h0);
    check("rst_gnt_valid", 64'(bus.gnt_valid), 64'h0);
    check("rst_gnt_idx",   64'(bus.gnt_idx),   64'h0);
    check("rst_timeout",   64'(bus.timeout),   64'h0);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rot_exp[4];
    int rot_n;
    int lo_cnt;
    logic [31:0] r;

    rot_exp = '{0, 4, 31, 0};
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.req  = 32'h0;
    bus.done = 1'b0;

    // Reset with every requester active, then first grant goes to requester 0
    do_reset();
    tick(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("first_idx", 64'(bus.gnt_idx), 64'd0);
    check("first_gnt", 64'(bus.gnt),     64'h1);

    // Rotation 0, 4, 31, 0 with done pulsed every busy cycle
    do_reset();
    rot_n = 0;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b1, 32'h8000_0011, (m_state == 1));
      if (t % 3 == 1) begin
        check("rot_idx",   64'(bus.gnt_idx),   64'(rot_exp[rot_n]));
        check("rot_valid", 64'(bus.gnt_valid), 64'd1);
        rot_n++;
      end else begin
        check("rot_gap", 64'(bus.gnt_valid), 64'd0);
      end
    end

    // Wrap after serving requester 31
    do_reset();
    tick(1'b1, 32'h8000_0000, 1'b0);
    check("wrap31_idx", 64'(bus.gnt_idx), 64'd31);
    tick(1'b1, 32'h8000_0000, 1'b1);
    tick(1'b1, 32'h0000_0004, 1'b0);
    tick(1'b1, 32'h0000_0004, 1'b0);
    check("wrap_idx", 64'(bus.gnt_idx), 64'd2);
    check("wrap_gnt", 64'(bus.gnt),     64'h4);

    // Release by request drop, then done while idle has no effect
    do_reset();
    tick(1'b1, 32'h0000_1080, 1'b0);
    check("drop_idx7", 64'(bus.gnt_idx), 64'd7);
    tick(1'b1, 32'h0000_1000, 1'b0);
    check("drop_rel_gnt", 64'(bus.gnt), 64'h0);
    tick(1'b1, 32'h0000_1000, 1'b0);
    check("drop_gap", 64'(bus.gnt_valid), 64'd0);
    tick(1'b1, 32'h0000_1000, 1'b0);
    check("drop_next_idx", 64'(bus.gnt_idx), 64'd12);
    tick(1'b1, 32'h0000_0000, 1'b0);
    for (int t = 0; t < 4; t++) tick(1'b1, 32'h0000_0000, 1'b1);
    check("idle_done", 64'(bus.gnt_valid), 64'd0);

    // Enable gating
    do_reset();
    lo_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 32'h0000_0100, 1'b0);
      if (bus.gnt_valid === 1'b0) lo_cnt++;
    end
    check("en_block_cycles", 64'(lo_cnt), 64'd10);
    tick(1'b1, 32'h0000_0100, 1'b0);
    check("en_idx8", 64'(bus.gnt_idx), 64'd8);
    for (int t = 0; t < 5; t++) tick(1'b0, 32'h0000_0100, 1'b0);
    check("en_hold_gnt", 64'(bus.gnt), 64'h100);
    tick(1'b0, 32'h0000_0100, 1'b1);
    check("en_release", 64'(bus.gnt_valid), 64'd0);
    for (int t = 0; t < 4; t++) tick(1'b0, 32'h0000_0100, 1'b0);
    check("en_no_regrant", 64'(bus.gnt_valid), 64'd0);

    // Long hold: forced release with the timeout build, indefinite otherwise
    do_reset();
    tick(1'b1, 32'h0000_0003, 1'b0);
    check("hold_idx0", 64'(bus.gnt_idx), 64'd0);
`ifdef ARB_TIMEOUT_EN
    for (int t = 0; t < 3; t++) tick(1'b1, 32'h0000_0003, 1'b0);
    check("to_held", 64'(bus.gnt_valid), 64'd1);
    tick(1'b1, 32'h0000_0003, 1'b0);
    check("to_pulse", 64'(bus.timeout),   64'd1);
    check("to_rel",   64'(bus.gnt_valid), 64'd0);
    tick(1'b1, 32'h0000_0003, 1'b0);
    check("to_pulse_end", 64'(bus.timeout), 64'd0);
    tick(1'b1, 32'h0000_0003, 1'b0);
    check("to_next_idx", 64'(bus.gnt_idx), 64'd1);
`else
    for (int t = 0; t < 20; t++) tick(1'b1, 32'h0000_0003, 1'b0);
    check("hold_valid", 64'(bus.gnt_valid), 64'd1);
    check("hold_gnt",   64'(bus.gnt),       64'h1);
    check("hold_no_to", 64'(bus.timeout),   64'd0);
`endif

    // Asynchronous reset in the middle of a grant
    do_reset();
    tick(1'b1, 32'h0000_0040, 1'b0);
    check("async_pre_idx", 64'(bus.gnt_idx), 64'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",   64'(bus.gnt),       64'h0);
    check("async_valid", 64'(bus.gnt_valid), 64'd0);
    check("async_idx",   64'(bus.gnt_idx),   64'd0);
    do_reset();
    tick(1'b1, 32'h0000_0041, 1'b0);
    check("async_ptr_idx", 64'(bus.gnt_idx), 64'd0);

    // Random traffic against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      r = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 5) == 0) r = 32'h0;
      tick(($urandom_range(0, 7) != 0), r, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec32_rr_arbiter.md
Name: dec32_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-way one-hot decoded resource among 32 requesters.
- Picks a winner, holds its 5-bit index registered, and drives the 32 one-hot grant lines.
- Grant lines come from the index as a 5-to-32 decode gated by a grant-valid enable, split as 4 banks of 8 selected by idx[4:3].
- Sits between the request sources (switch/LED bank logic) and the shared decoder outputs.

Parameters:
- MAX_HOLD, 16, maximum number of BUSY cycles before forced release (used only when ARB_TIMEOUT_EN is defined); legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  arbitration enable; low blocks new grants only
- req  input  32  request vector, bit i = requester i
- done  input  1  pulse from the current owner releasing the grant
- gnt  output  32  one-hot grant; all zero when gnt_valid=0
- gnt_idx  output  5  index of the current owner
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset is asynchronous, active-low, one clock domain. While rst_n=0:
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - last pointer=31, so the first search starts at requester 0.
- State machine: IDLE, BUSY, GAP.
- IDLE:
  - If en=1 and req!=0, search bits (last+1) mod 32 upward, wrapping at 31->0. The first set bit wins.
  - On that edge: gnt_idx=winner, gnt_valid=1, last=winner, go to BUSY.
  - Latency is 1 clock from req sampled to gnt asserted.
  - If en=0 or req=0, stay in IDLE.
- BUSY:
  - gnt = decode(gnt_idx), exactly one bit set.
  - Release when done=1 OR req[gnt_idx]=0, sampled at the clock edge.
  - On release: gnt_valid=0, gnt=0, go to GAP. gnt_idx holds its last value.
- GAP:
  - One dead cycle with grant deasserted, guaranteeing break-before-make.
  - Unconditionally go to IDLE.
  - Minimum spacing between two grants is 2 cycles from release.
- en deasserted during BUSY: current grant continues until release. No new grant is issued while en=0.
- done while not in BUSY: ignored.
- done and drop of req on the same edge: a single release.
- Single requester asserting continuously: re-granted every third cycle at best (BUSY, GAP, IDLE), with the pointer unchanged in effect.
- Fairness: after requester i is served, every other pending requester is served before i again.
- Index arithmetic is 5-bit modulo 32. The wrap from 31 to 0 is natural overflow.
- gnt is combinationally derived from the registered gnt_idx and gnt_valid; no glitch source other than the registers.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and the pointer returns to 31.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 and no release is occurring, force release: go to GAP and pulse timeout=1 for one cycle.
  - The pointer still advances past the owner.
  - A normal release on the same edge takes priority (timeout=0).
- When undefined:
  - No counter; a grant is held indefinitely until done or req drop.
  - timeout is constant 0.

Test Plan:
- Reset: rst_n=0 with req=32'hFFFFFFFF -> gnt=0, gnt_valid=0. Release reset, en=1 -> after 1 edge gnt_idx=0, gnt=32'h00000001.
- Rotation: req=32'h80000011 held, done pulsed each BUSY cycle -> grants in order 0, 4, 31, 0, each separated by one GAP cycle and one IDLE cycle.
- Wrap: last=31 forced by serving requester 31, then req=32'h00000004 -> gnt_idx=2, gnt=32'h00000004.
- Release by drop: grant to 7, deassert req[7] without done -> gnt=0 on next edge, then GAP, then next requester granted. Also assert done in IDLE -> no effect.
- en gating: en=0 with req=32'h00000100 -> no grant for 10 cycles. Drop en during BUSY on idx 8 -> grant held until done.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=32'h00000003, never pulse done -> grant idx 0 for 4 cycles, timeout pulse, GAP, then idx 1. Async reset asserted mid-BUSY -> outputs 0 within the same cycle.
